// File: rtl/fan_ctrl.sv
// Fan controller: OFF/KICK/RUN/STALL FSM with a ms-tick control loop nudging PWM duty toward a target tach period.
// Define FAN_CTRL_AUTO_RESTART_EN to let STALL retry a KICK after RETRY_MS; otherwise STALL holds until ctrl_en drops.
module fan_ctrl #(
    parameter int          KICK_MS    = 500,
    parameter int          CTRL_MS    = 100,
    parameter logic [7:0]  STEP       = 8'd2,
    parameter logic [7:0]  MIN_PCT    = 8'h30,
    parameter logic [7:0]  MAX_PCT    = 8'hFF,
    parameter logic [19:0] STALL_USPR = 20'd500000,
    parameter int          STALL_CNT  = 3,
    parameter int          RETRY_MS   = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tsc_1ppms,
    input  logic        ctrl_en,
    input  logic [19:0] target_uspr,
    input  logic [19:0] fan_uspr,
    output logic [7:0]  fan_pct,
    output logic [1:0]  fan_state,
    output logic        fan_stall
);

    // Counter is wide enough for the longest interval, but never narrower than 12 bits.
    localparam int MAX_A = (KICK_MS > CTRL_MS) ? KICK_MS : CTRL_MS;
    localparam int MAX_B = (MAX_A > RETRY_MS) ? MAX_A : RETRY_MS;
    localparam int MS_W  = ($clog2(MAX_B + 1) > 12) ? $clog2(MAX_B + 1) : 12;
    localparam int SC_W  = ($clog2(STALL_CNT + 1) > 1) ? $clog2(STALL_CNT + 1) : 1;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_KICK  = 2'b01,
        ST_RUN   = 2'b10,
        ST_STALL = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [MS_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [7:0]        fan_pct_q, fan_pct_d;
    logic              fan_stall_q, fan_stall_d;

    logic [8:0]        duty_up;
    logic [8:0]        duty_dn;
    logic [7:0]        pct_up;
    logic [7:0]        pct_dn;
    logic [7:0]        pct_adj;
    logic [SC_W-1:0]   stall_next;
    logic              stalled;

    // 9-bit sums expose carry/borrow so the duty clamps instead of wrapping.
    always_comb begin
        duty_up    = {1'b0, fan_pct_q} + {1'b0, STEP};
        duty_dn    = {1'b0, fan_pct_q} - {1'b0, STEP};
        pct_up     = (duty_up > {1'b0, MAX_PCT}) ? MAX_PCT : duty_up[7:0];
        pct_dn     = (duty_dn[8] || (duty_dn < {1'b0, MIN_PCT})) ? MIN_PCT : duty_dn[7:0];
        stalled    = (fan_uspr >= STALL_USPR);
        stall_next = stall_cnt_q + SC_W'(1);
        if (fan_uspr > target_uspr) begin
            pct_adj = pct_up;
        end else if (fan_uspr < target_uspr) begin
            pct_adj = pct_dn;
        end else begin
            pct_adj = fan_pct_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        ms_cnt_d    = ms_cnt_q;
        stall_cnt_d = stall_cnt_q;
        fan_pct_d   = fan_pct_q;
        fan_stall_d = fan_stall_q;
        if (!ctrl_en) begin
            state_d     = ST_OFF;
            ms_cnt_d    = '0;
            stall_cnt_d = '0;
            fan_pct_d   = 8'h00;
            fan_stall_d = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d     = ST_KICK;
                    ms_cnt_d    = '0;
                    stall_cnt_d = '0;
                    fan_pct_d   = MAX_PCT;
                    fan_stall_d = 1'b0;
                end
                ST_KICK: begin
                    if (tsc_1ppms) begin
                        if (ms_cnt_q == MS_W'(KICK_MS - 1)) begin
                            state_d     = ST_RUN;
                            ms_cnt_d    = '0;
                            stall_cnt_d = '0;
                            fan_pct_d   = MAX_PCT;
                        end else begin
                            ms_cnt_d = ms_cnt_q + MS_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (tsc_1ppms) begin
                        if (ms_cnt_q == MS_W'(CTRL_MS - 1)) begin
                            ms_cnt_d = '0;
                            if (stalled && (stall_next == SC_W'(STALL_CNT))) begin
                                state_d     = ST_STALL;
                                stall_cnt_d = '0;
                                fan_pct_d   = 8'h00;
                                fan_stall_d = 1'b1;
                            end else begin
                                stall_cnt_d = stalled ? stall_next : '0;
                                fan_pct_d   = pct_adj;
                            end
                        end else begin
                            ms_cnt_d = ms_cnt_q + MS_W'(1);
                        end
                    end
                end
                ST_STALL: begin
`ifdef FAN_CTRL_AUTO_RESTART_EN
                    if (tsc_1ppms) begin
                        if (ms_cnt_q == MS_W'(RETRY_MS - 1)) begin
                            state_d     = ST_KICK;
                            ms_cnt_d    = '0;
                            fan_pct_d   = MAX_PCT;
                            fan_stall_d = 1'b0;
                        end else begin
                            ms_cnt_d = ms_cnt_q + MS_W'(1);
                        end
                    end
`else
                    ms_cnt_d = '0;
`endif
                end
                default: begin
                    state_d     = ST_OFF;
                    ms_cnt_d    = '0;
                    stall_cnt_d = '0;
                    fan_pct_d   = 8'h00;
                    fan_stall_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            ms_cnt_q    <= '0;
            stall_cnt_q <= '0;
            fan_pct_q   <= 8'h00;
            fan_stall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ms_cnt_q    <= ms_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            fan_pct_q   <= fan_pct_d;
            fan_stall_q <= fan_stall_d;
        end
    end

    assign fan_pct   = fan_pct_q;
    assign fan_state = state_q;
    assign fan_stall = fan_stall_q;

endmodule

// File: tb/tb_fan_ctrl.sv
// Directed self-checking bench for fan_ctrl: expectations are queued per step and drained against the DUT outputs.
// Follows FAN_CTRL_AUTO_RESTART_EN to pick the STALL-exit expectations.
module tb_fan_ctrl;

    localparam logic [1:0] S_OFF   = 2'b00;
    localparam logic [1:0] S_KICK  = 2'b01;
    localparam logic [1:0] S_RUN   = 2'b10;
    localparam logic [1:0] S_STALL = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tsc_1ppms;
    logic        ctrl_en;
    logic [19:0] target_uspr;
    logic [19:0] fan_uspr;
    logic [7:0]  fan_pct;
    logic [1:0]  fan_state;
    logic        fan_stall;

    int          checks = 0;
    int          errors = 0;
    int          exp_pct;
    string       tag_q[$];
    logic [10:0] exp_q[$];

    fan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tsc_1ppms  (tsc_1ppms),
        .ctrl_en    (ctrl_en),
        .target_uspr(target_uspr),
        .fan_uspr   (fan_uspr),
        .fan_pct    (fan_pct),
        .fan_state  (fan_state),
        .fan_stall  (fan_stall)
    );

    always #5 clk = ~clk;

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    // One ms tick is a single-clk pulse followed by an idle clk.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            tsc_1ppms = 1'b1;
            step_clk();
            tsc_1ppms = 1'b0;
            step_clk();
        end
    endtask

    task automatic push_expect(input string tag, input logic [1:0] st,
                               input logic [7:0] pct, input logic stall);
        tag_q.push_back(tag);
        exp_q.push_back({st, pct, stall});
    endtask

    task automatic checkOutput();
        string       t;
        logic [10:0] e;
        while (tag_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            assert (fan_state === e[10:9]) else begin
                errors++;
                $error("[TB] FAIL %s fan_state observed=%0h expected=%0h", t, fan_state, e[10:9]);
            end
            checks++;
            assert (fan_pct === e[8:1]) else begin
                errors++;
                $error("[TB] FAIL %s fan_pct observed=%0h expected=%0h", t, fan_pct, e[8:1]);
            end
            checks++;
            assert (fan_stall === e[0]) else begin
                errors++;
                $error("[TB] FAIL %s fan_stall observed=%0h expected=%0h", t, fan_stall, e[0]);
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        ctrl_en     = 1'b0;
        tsc_1ppms   = 1'b0;
        target_uspr = 20'd30000;
        fan_uspr    = 20'd20000;

        repeat (3) step_clk();
        push_expect("reset", S_OFF, 8'h00, 1'b0);
        checkOutput();

        ctrl_en = 1'b1;
        step_clk();
        push_expect("reset_beats_enable", S_OFF, 8'h00, 1'b0);
        checkOutput();

        rst_n = 1'b1;
        step_clk();
        push_expect("enter_kick", S_KICK, 8'hFF, 1'b0);
        checkOutput();

        applyStimulus(499);
        push_expect("kick_499", S_KICK, 8'hFF, 1'b0);
        checkOutput();
        applyStimulus(1);
        push_expect("kick_done", S_RUN, 8'hFF, 1'b0);
        checkOutput();

        applyStimulus(99);
        push_expect("run_before_update", S_RUN, 8'hFF, 1'b0);
        checkOutput();
        applyStimulus(1);
        push_expect("run_first_update", S_RUN, 8'hFD, 1'b0);
        checkOutput();

        exp_pct = 253;
        for (int u = 0; u < 104; u++) begin
            applyStimulus(100);
            exp_pct = (exp_pct - 2 < 48) ? 48 : exp_pct - 2;
            push_expect("run_down", S_RUN, exp_pct[7:0], 1'b0);
            checkOutput();
        end
        push_expect("run_floor", S_RUN, 8'h30, 1'b0);
        checkOutput();

        target_uspr = 20'd0;
        applyStimulus(100);
        push_expect("target_zero", S_RUN, 8'h32, 1'b0);
        checkOutput();

        target_uspr = 20'd30000;
        fan_uspr    = 20'hFFFFF;
        applyStimulus(100);
        push_expect("stall_upd1", S_RUN, 8'h34, 1'b0);
        checkOutput();
        applyStimulus(100);
        push_expect("stall_upd2", S_RUN, 8'h36, 1'b0);
        checkOutput();
        fan_uspr = 20'd20000;
        applyStimulus(100);
        push_expect("stall_cleared", S_RUN, 8'h34, 1'b0);
        checkOutput();

        fan_uspr = 20'hFFFFF;
        applyStimulus(200);
        push_expect("stall_again2", S_RUN, 8'h38, 1'b0);
        checkOutput();
        applyStimulus(100);
        push_expect("stall_enter", S_STALL, 8'h00, 1'b1);
        checkOutput();
        fan_uspr = 20'd20000;

`ifdef FAN_CTRL_AUTO_RESTART_EN
        applyStimulus(1999);
        push_expect("retry_wait", S_STALL, 8'h00, 1'b1);
        checkOutput();
        applyStimulus(1);
        push_expect("retry_kick", S_KICK, 8'hFF, 1'b0);
        checkOutput();
`else
        applyStimulus(5000);
        push_expect("stall_hold", S_STALL, 8'h00, 1'b1);
        checkOutput();
`endif

        ctrl_en = 1'b0;
        step_clk();
        push_expect("disable_off", S_OFF, 8'h00, 1'b0);
        checkOutput();

        ctrl_en   = 1'b1;
        tsc_1ppms = 1'b1;
        step_clk();
        tsc_1ppms = 1'b0;
        push_expect("reenter_kick", S_KICK, 8'hFF, 1'b0);
        checkOutput();
        applyStimulus(499);
        push_expect("kick_tick_not_counted", S_KICK, 8'hFF, 1'b0);
        checkOutput();
        applyStimulus(1);
        push_expect("kick_done2", S_RUN, 8'hFF, 1'b0);
        checkOutput();

        applyStimulus(99);
        tsc_1ppms = 1'b1;
        ctrl_en   = 1'b0;
        step_clk();
        tsc_1ppms = 1'b0;
        push_expect("drop_on_update", S_OFF, 8'h00, 1'b0);
        checkOutput();

        ctrl_en = 1'b1;
        step_clk();
        push_expect("kick_after_drop", S_KICK, 8'hFF, 1'b0);
        checkOutput();
        applyStimulus(500);
        push_expect("run_after_drop", S_RUN, 8'hFF, 1'b0);
        checkOutput();
        applyStimulus(100);
        push_expect("counter_cleared", S_RUN, 8'hFD, 1'b0);
        checkOutput();

        rst_n = 1'b0;
        step_clk();
        push_expect("reset_mid_run", S_OFF, 8'h00, 1'b0);
        checkOutput();
        rst_n = 1'b1;
        step_clk();
        push_expect("kick_after_reset", S_KICK, 8'hFF, 1'b0);
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
